// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side controller.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH  = 32;
  localparam int READER_BUF_DEPTH = 3;
  localparam int READER_PTR_WIDTH = 2;

  typedef logic [READER_PTR_WIDTH-1:0] rd_ptr_t;

  // Circular pointer advance over a depth that is not a power of two.
  function automatic rd_ptr_t ptr_next(input rd_ptr_t p);
    return (p == rd_ptr_t'(READER_BUF_DEPTH - 1)) ? '0 : rd_ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream stream port of the reader, bundled as one interface.
interface fifo_stream_reader_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Stream handshake: a word transfers on a rising clk edge where m_valid && m_ready.
  // Once m_valid is high, m_valid and m_data hold until that transfer; m_valid never
  // depends on m_ready.
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_cs, fifo_rd_en, m_valid, m_data,
    input  fifo_empty, fifo_data, m_ready
  );

  modport slave (
    input  fifo_cs, fifo_rd_en, m_valid, m_data,
    output fifo_empty, fifo_data, m_ready
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Three-entry circular buffer that absorbs the FIFO read latency; push/pop with occupancy.
module fifo_reader_skid import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output rd_ptr_t               count
);

  logic [DATA_WIDTH-1:0] mem [READER_BUF_DEPTH];
  rd_ptr_t head_q;
  rd_ptr_t tail_q;
  rd_ptr_t occ_q;
  logic    pop_ok;

  assign pop_ok = pop && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < READER_BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail_q] <= push_data;
        tail_q      <= ptr_next(tail_q);
      end
      if (pop_ok) head_q <= ptr_next(head_q);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop_ok})
        2'b10:   occ_q <= rd_ptr_t'(occ_q + 1'b1);
        2'b01:   occ_q <= rd_ptr_t'(occ_q - 1'b1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = mem[head_q];
  assign count     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues reads, buffers words, streams them out.
// Optional delivered-word counter port/register compiled in with FIFO_READER_COUNT_EN.
module fifo_stream_reader import fifo_pkg::*; #(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  fifo_stream_reader_if.master   bus,
  output logic                   busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] word_count
`endif
);

  logic                  inflight_q;
  logic                  rd_en;
  logic                  pop;
  logic [2:0]            outstanding;
  rd_ptr_t               occ;
  logic [DATA_WIDTH-1:0] head_data;

  // Reads are granted from registered state only, so a stalled sink cannot overfill the buffer.
  assign outstanding = {1'b0, occ} + {2'b00, inflight_q};
  assign rd_en       = rst_n && enable && !bus.fifo_empty &&
                       (outstanding < 3'(READER_BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= rd_en;
  end

  fifo_reader_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (occ)
  );

  assign bus.fifo_cs    = enable;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != '0);
  assign bus.m_data     = head_data;
  assign pop            = bus.m_valid && bus.m_ready;
  assign busy           = (occ != '0) || inflight_q;

`ifdef FIFO_READER_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n)   count_q <= '0;
    else if (pop) count_q <= count_q + 1'b1;
  end

  assign word_count = count_q;
`else
  logic [COUNT_WIDTH-1:0] count_unused;
  assign count_unused = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, transaction-level scoreboard, directed and random phases.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;
`ifdef FIFO_READER_COUNT_EN
  logic [CW-1:0] word_count;
`endif

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus),
    .busy   (busy)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model (registered read data, one-cycle latency) ----------------
  logic [DW-1:0] fq[$];
  logic          fifo_empty_r = 1'b1;
  logic [DW-1:0] fifo_data_r = '0;
  logic          force_ne = 1'b0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          m_ready = 1'b0;

  assign bus.fifo_empty = fifo_empty_r && !force_ne;
  assign bus.fifo_data  = fifo_data_r;
  assign bus.m_ready    = m_ready;

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_data_r <= '0;
    end else begin
      if (bus.fifo_rd_en && bus.fifo_cs && fq.size() != 0) fifo_data_r <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
    end
    fifo_empty_r <= (fq.size() == 0);
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int pulses = 0;      // reads issued since reset
  int pulses_lag = 0;  // reads issued up to two cycles ago (already captured)
  int accepted = 0;    // words accepted by the sink since reset
  int cyc, first_rd, first_val, phase_rd, phase_acc;
  int rd_run, rd_run_max, acc_run, acc_run_max, empty_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic phase_clear();
    cyc = 0; first_rd = -1; first_val = -1; phase_rd = 0; phase_acc = 0;
    rd_run = 0; rd_run_max = 0; acc_run = 0; acc_run_max = 0; empty_rd = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then cross the rising edge.
  task automatic cycle();
    logic          rd;
    logic          acc;
    logic [DW-1:0] want;
    @(negedge clk);
    rd  = bus.fifo_rd_en;
    acc = bus.m_valid && bus.m_ready;
    chk("rd_en", rd, rst_n && enable && !bus.fifo_empty && ((pulses - accepted) < 3));
    chk("m_valid", bus.m_valid, (pulses_lag - accepted) > 0);
    chk("busy", busy, (pulses - accepted) > 0);
    if (bus.m_valid) begin
      want = (exp_q.size() != 0) ? exp_q[0] : 'x;
      chk("m_data", bus.m_data, want);
    end
`ifdef FIFO_READER_COUNT_EN
    chk("word_count", word_count, CW'(accepted));
`endif
    if (rd && bus.fifo_empty) empty_rd++;
    pulses_lag = pulses;
    if (rst_n && rd && !bus.fifo_empty) pulses++;
    if (acc && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      accepted++;
    end
    cyc++;
    if (rd) begin
      phase_rd++;
      if (first_rd < 0) first_rd = cyc;
      rd_run++;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
    end else rd_run = 0;
    if (bus.m_valid && first_val < 0) first_val = cyc;
    if (acc) begin
      phase_acc++;
      acc_run++;
      if (acc_run > acc_run_max) acc_run_max = acc_run;
    end else acc_run = 0;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      pulses = 0; pulses_lag = 0; accepted = 0;
    end else if (wr_req) exp_q.push_back(wr_data);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_req = 1'b1;
      wr_data = base + DW'(i);
      cycle();
    end
    wr_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    phase_clear();
    rst_n = 1'b0; enable = 1'b1; force_ne = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with a non-empty FIFO flag and enable high.
    run(2);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef FIFO_READER_COUNT_EN
    chk("rst_word_count", word_count, '0);
`endif
    rst_n = 1'b1; force_ne = 1'b0; enable = 1'b0;

    // Streaming: 8 preloaded words, sink always ready.
    load(32'hA0, 8);
    phase_clear();
    enable = 1'b1; m_ready = 1'b1;
    run(14);
    chk("stream_rd_pulses", phase_rd, 8);
    chk("stream_rd_consecutive", rd_run_max, 8);
    chk("stream_valid_latency", first_val - first_rd, 2);
    chk("stream_delivered", phase_acc, 8);
    chk("stream_back_to_back", acc_run_max, 8);
`ifdef FIFO_READER_COUNT_EN
    chk("stream_word_count", word_count, 16'd8);
`endif

    // Backpressure: sink stalled, only three reads may run ahead.
    enable = 1'b0;
    load(32'hB0, 6);
    phase_clear();
    enable = 1'b1; m_ready = 1'b0;
    run(8);
    chk("bp_rd_pulses", phase_rd, 3);
    chk("bp_hold_valid", bus.m_valid, 1'b1);
    chk("bp_hold_data", bus.m_data, 32'hB0);
    m_ready = 1'b1;
    run(12);
    chk("bp_delivered", phase_acc, 6);
    chk("bp_total_reads", phase_rd, 6);

    // Empty handling: one word written every four cycles.
    phase_clear();
    for (int k = 0; k < 5; k++) begin
      wr_req = 1'b1; wr_data = 32'hC0 + DW'(k);
      cycle();
      wr_req = 1'b0;
      run(3);
    end
    run(2);
    chk("empty_no_rd_when_empty", empty_rd, 0);
    chk("empty_rd_pulses", phase_rd, 5);
    chk("empty_delivered", phase_acc, 5);

    // Enable drop right after one read.
    enable = 1'b0;
    load(32'hD0, 4);
    phase_clear();
    enable = 1'b1;
    cycle();
    chk("edrop_first_rd", phase_rd, 1);
    enable = 1'b0;
    run(6);
    chk("edrop_rd_pulses", phase_rd, 1);
    chk("edrop_delivered", phase_acc, 1);
    chk("edrop_busy_low", busy, 1'b0);

    // Mid-stream reset with three buffered words.
    m_ready = 1'b0; enable = 1'b1;
    run(5);
    chk("mrst_buffered_valid", bus.m_valid, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mrst_m_valid", bus.m_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
`ifdef FIFO_READER_COUNT_EN
    chk("mrst_word_count", word_count, '0);
`endif
    enable = 1'b0;
    cycle();

    // Random traffic on all inputs.
    for (int i = 0; i < 600; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      wr_req  = ($urandom_range(0, 1) != 0);
      wr_data = $urandom;
      cycle();
    end

    // Drain with a bounded budget.
    wr_req = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cycle();
    chk("drain_all_delivered", exp_q.size(), 0);
    run(2);
    chk("drain_busy_low", busy, 1'b0);
    chk("drain_valid_low", bus.m_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
